mem_arbiter: RTL and testbench

// Shares the single 8-bit memory port between the CPU core and one DMA requester (video/loader).

---
 rtl/mem_arbiter_pkg.sv | 16 +
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Bus encodings shared by the core, the DMA engine and the memory arbiter.
package mem_arbiter_pkg;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Bit positions of each requester in per-owner vectors.
  localparam int OWN_CPU = 0;
  localparam int OWN_DMA = 1;
  localparam int NUM_OWN = 2;

  function automatic logic is_read(input logic rw);
    return rw != RW_WRITE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one memory port between CPU and DMA, with DMA cycle-stealing bounded by MAX_BURST.
// Grant is combinational in the request cycle; read data returns 1 cycle later; a losing CPU is held off via cpu_rdy.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int AW        = 16,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_rw,
  input  logic [AW-1:0] cpu_ad,
  input  logic [DW-1:0] cpu_dout,
  output logic          cpu_rdy,
  output logic [DW-1:0] cpu_din,
  output logic          cpu_dvalid,
  input  logic          dma_req,
  input  logic          dma_rw,
  input  logic [AW-1:0] dma_ad,
  input  logic [DW-1:0] dma_dout,
  output logic          dma_gnt,
  output logic [DW-1:0] dma_din,
  output logic          dma_dvalid,
  output logic [AW-1:0] mem_ad,
  output logic          mem_rw,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din
);

  localparam int              BCW       = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] BURST_LIM = BCW'(MAX_BURST);

  logic [BCW-1:0]     burst_cnt;
  logic [NUM_OWN-1:0] rd_own;
  logic               cpu_gnt;
  logic               burst_hit;

  // DMA only yields once it has stolen MAX_BURST cycles from a waiting CPU.
  assign burst_hit = cpu_req && (burst_cnt == BURST_LIM);
  assign dma_gnt   = dma_req && !burst_hit;
  assign cpu_gnt   = cpu_req && !dma_gnt;
  assign cpu_rdy   = cpu_gnt || !cpu_req;

  always_comb begin
    mem_ad   = '0;
    mem_rw   = RW_READ;
    mem_dout = '0;
    if (dma_gnt) begin
      mem_ad   = dma_ad;
      mem_rw   = dma_rw;
      mem_dout = dma_dout;
    end else if (cpu_gnt) begin
      mem_ad   = cpu_ad;
      mem_rw   = cpu_rw;
      mem_dout = cpu_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt <= '0;
      rd_own    <= '0;
    end else begin
      rd_own[OWN_CPU] <= cpu_gnt && is_read(cpu_rw);
      rd_own[OWN_DMA] <= dma_gnt && is_read(dma_rw);
      if (cpu_gnt || !cpu_req)
        burst_cnt <= '0;
      else if (dma_gnt && (burst_cnt != BURST_LIM))
        burst_cnt <= burst_cnt + 1'b1;
    end
  end

  // Memory read data is broadcast; each consumer qualifies it with its own dvalid.
  assign cpu_dvalid = rd_own[OWN_CPU];
  assign dma_dvalid = rd_own[OWN_DMA];
  assign cpu_din    = mem_din;
  assign dma_din    = mem_din;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed per-cycle vectors with hand-assigned expected owner.
module tb_mem_arbiter;

  localparam int G_N = 0;
  localparam int G_C = 1;
  localparam int G_D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_rw, dma_req, dma_rw;
  logic [15:0] cpu_ad, dma_ad, mem_ad;
  logic [7:0]  cpu_dout, dma_dout, mem_dout, mem_din, cpu_din, dma_din;
  logic        cpu_rdy, cpu_dvalid, dma_gnt, dma_dvalid, mem_rw;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rdy;
    logic        gnt;
    logic [15:0] ad;
    logic        rw;
    logic [7:0]  dout;
    logic        cdv;
    logic        ddv;
  } cyc_t;

  typedef struct {
    logic       own;
    logic [7:0] dat;
  } rd_t;

  cyc_t exp_q[$];
  rd_t  rd_q[$];
  logic prev_c = 1'b0;
  logic prev_d = 1'b0;

  mem_arbiter #(.AW(16), .DW(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_ad(cpu_ad), .cpu_dout(cpu_dout),
    .cpu_rdy(cpu_rdy), .cpu_din(cpu_din), .cpu_dvalid(cpu_dvalid),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_ad(dma_ad), .dma_dout(dma_dout),
    .dma_gnt(dma_gnt), .dma_din(dma_din), .dma_dvalid(dma_dvalid),
    .mem_ad(mem_ad), .mem_rw(mem_rw), .mem_dout(mem_dout), .mem_din(mem_din)
  );

  always #5 clk = ~clk;

  // Synchronous memory: returns address low byte ^ 0x5A one cycle later.
  always @(posedge clk) mem_din <= mem_ad[7:0] ^ 8'h5A;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Drive one clock of stimulus and push what the DUT must show during it.
  task automatic cyc(input logic r, input logic cq, input logic crw, input logic [15:0] cad,
                     input logic [7:0] cdo, input logic dq, input logic drw,
                     input logic [15:0] dad, input logic [7:0] ddo, input int g);
    cyc_t e;
    @(posedge clk);
    #1;
    rst_n = r; cpu_req = cq; cpu_rw = crw; cpu_ad = cad; cpu_dout = cdo;
    dma_req = dq; dma_rw = drw; dma_ad = dad; dma_dout = ddo;
    e.rdy  = (g == G_C) || !cq;
    e.gnt  = (g == G_D);
    e.ad   = (g == G_D) ? dad : (g == G_C) ? cad : 16'h0000;
    e.rw   = (g == G_D) ? drw : (g == G_C) ? crw : 1'b1;
    e.dout = (g == G_D) ? ddo : (g == G_C) ? cdo : 8'h00;
    e.cdv  = prev_c;
    e.ddv  = prev_d;
    exp_q.push_back(e);
    prev_c = r && (g == G_C) && crw;
    prev_d = r && (g == G_D) && drw;
    if (prev_c) rd_q.push_back('{1'b0, cad[7:0] ^ 8'h5A});
    if (prev_d) rd_q.push_back('{1'b1, dad[7:0] ^ 8'h5A});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 1, 16'h0, 8'h0, 0, 1, 16'h0, 8'h0, G_N);
  endtask

  // Both requesters reading continuously; g lists the expected owner per cycle.
  task automatic both_rd(input logic r, input logic [15:0] cad, input logic [15:0] dad, input int g);
    cyc(r, 1, 1, cad, 8'h11, 1, 1, dad, 8'h22, g);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cyc_t e;
      e = exp_q.pop_front();
      chk("cpu_rdy", 32'(cpu_rdy), 32'(e.rdy));
      chk("dma_gnt", 32'(dma_gnt), 32'(e.gnt));
      chk("mem_ad", 32'(mem_ad), 32'(e.ad));
      chk("mem_rw", 32'(mem_rw), 32'(e.rw));
      chk("mem_dout", 32'(mem_dout), 32'(e.dout));
      chk("cpu_dvalid", 32'(cpu_dvalid), 32'(e.cdv));
      chk("dma_dvalid", 32'(dma_dvalid), 32'(e.ddv));
      if (cpu_dvalid || dma_dvalid) begin
        if (rd_q.size() == 0) begin
          chk("unexpected_read_data", 32'(1), 32'(0));
        end else begin
          rd_t d;
          d = rd_q.pop_front();
          chk("read_owner", 32'(dma_dvalid), 32'(d.own));
          chk("read_data", 32'(cpu_dvalid ? cpu_din : dma_din), 32'(d.dat));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; cpu_req = 1'b0; cpu_rw = 1'b1; cpu_ad = '0; cpu_dout = '0;
    dma_req = 1'b0; dma_rw = 1'b1; dma_ad = '0; dma_dout = '0;
    @(posedge clk);
    cyc(0, 0, 1, 16'h0, 8'h0, 0, 1, 16'h0, 8'h0, G_N);
    cyc(0, 0, 1, 16'h0, 8'h0, 0, 1, 16'h0, 8'h0, G_N);

    // CPU-only reads, data 5A,5B,58,59
    for (int i = 0; i < 4; i++) cyc(1, 1, 1, 16'(i), 8'h00, 0, 1, 16'h0, 8'h0, G_C);
    idle(1);

    // DMA-only write
    cyc(1, 0, 1, 16'h0, 8'h0, 1, 0, 16'h4000, 8'hC3, G_D);
    idle(1);

    // Continuous contention: D,D,D,D,C twice
    for (int i = 0; i < 10; i++)
      both_rd(1, 16'h0100 + 16'(i), 16'h2000 + 16'(i), ((i % 5) == 4) ? G_C : G_D);
    idle(1);

    // DMA drops after two grants; CPU gets the next cycle and the counter restarts
    both_rd(1, 16'h0300, 16'h2100, G_D);
    both_rd(1, 16'h0301, 16'h2101, G_D);
    cyc(1, 1, 1, 16'h0302, 8'h0, 0, 1, 16'h0, 8'h0, G_C);
    for (int i = 0; i < 5; i++)
      both_rd(1, 16'h0310 + 16'(i), 16'h2110 + 16'(i), (i == 4) ? G_C : G_D);
    idle(1);

    // CPU read granted in a reset cycle: its data is discarded
    cyc(0, 1, 1, 16'h0033, 8'h0, 0, 1, 16'h0, 8'h0, G_C);
    idle(1);

    // Reset mid-burst clears the burst counter
    both_rd(1, 16'h0400, 16'h2200, G_D);
    both_rd(1, 16'h0401, 16'h2201, G_D);
    both_rd(0, 16'h0402, 16'h2202, G_D);
    for (int i = 0; i < 5; i++)
      both_rd(1, 16'h0410 + 16'(i), 16'h2210 + 16'(i), (i == 4) ? G_C : G_D);

    // CPU write under no contention, then a long idle stretch
    cyc(1, 1, 0, 16'h0500, 8'hA5, 0, 1, 16'h0, 8'h0, G_C);
    idle(10);

    @(negedge clk);
    #1;
    chk("read_queue_drained", 32'(rd_q.size()), 32'(0));
    chk("cycle_queue_drained", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
